// File: rtl/actuador_valvulas.sv
// ---------------------------------------------------------------------------
// actuador_valvulas
//
// Purpose:
//   Drives two independent valve/pump outputs from the level controller's
//   per-tank water request and error flags. Each channel enforces:
//   - a minimum on-time;
//   - a minimum off-time (cool-down);
//   - a maximum continuous run time.
//   A fault or a run timeout latches the channel into a lockout alarm.
//   The lockout is cleared only by an operator acknowledge.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   C[1:0]       water request per channel (1 = request water)
//   Pout[1:0]    error flag per channel (1 = error)
//   ack          operator acknowledge, level-sensitive, shared by both channels
//   V[1:0]       valve drive per channel (registered)
//   Alarm[1:0]   channel is in lockout (registered)
//   Tout[1:0]    lockout cause: 1 = timeout, 0 = fault; meaningful only while
//                Alarm is high (registered)
// ---------------------------------------------------------------------------
module actuador_valvulas #(
  parameter int MIN_ON  = 4,
  parameter int MIN_OFF = 4,
  parameter int MAX_ON  = 16,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] C,
  input  logic [1:0] Pout,
  input  logic       ack,
  output logic [1:0] V,
  output logic [1:0] Alarm,
  output logic [1:0] Tout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    COOL = 2'd2,
    LOCK = 2'd3
  } state_t;

  localparam logic [CW-1:0] MIN_ON_M1  = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] MIN_OFF_M1 = CW'(MIN_OFF - 1);
  localparam logic [CW-1:0] MAX_ON_M1  = CW'(MAX_ON - 1);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      state_t        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [CW-1:0] cnt_inc;
      logic          tout_q, tout_d;
      logic          v_q, alarm_q, tout_out_q;

      // Saturating increment; the counter must never wrap back to zero.
      assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tout_d  = tout_q;
        case (state_q)
          IDLE: begin
            if (Pout[gi]) begin
              state_d = LOCK;
              tout_d  = 1'b0;
              cnt_d   = '0;
            end else if (C[gi]) begin
              state_d = RUN;
              cnt_d   = '0;
            end
          end
          RUN: begin
            // A release is checked before the timeout. A release on the same
            // edge as the timeout therefore goes to COOL, not LOCK.
            if (Pout[gi]) begin
              state_d = LOCK;
              tout_d  = 1'b0;
              cnt_d   = '0;
            end else if (!C[gi] && (cnt_q >= MIN_ON_M1)) begin
              state_d = COOL;
              cnt_d   = '0;
            end else if (cnt_q == MAX_ON_M1) begin
              state_d = LOCK;
              tout_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          COOL: begin
            if (Pout[gi]) begin
              state_d = LOCK;
              tout_d  = 1'b0;
              cnt_d   = '0;
            end else if (cnt_q == MIN_OFF_M1) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          LOCK: begin
            // The cause stays frozen while locked. A late fault after a
            // timeout does not rewrite it.
            if (ack && !Pout[gi]) begin
              state_d = IDLE;
              tout_d  = 1'b0;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
            tout_d  = 1'b0;
          end
        endcase
      end

      // Outputs are registered from the next state. They therefore line up
      // with the state register and carry no combinational input path.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          tout_q     <= 1'b0;
          v_q        <= 1'b0;
          alarm_q    <= 1'b0;
          tout_out_q <= 1'b0;
        end else begin
          state_q    <= state_d;
          cnt_q      <= cnt_d;
          tout_q     <= tout_d;
          v_q        <= (state_d == RUN);
          alarm_q    <= (state_d == LOCK);
          tout_out_q <= (state_d == LOCK) && tout_d;
        end
      end

      assign V[gi]     = v_q;
      assign Alarm[gi] = alarm_q;
      assign Tout[gi]  = tout_out_q;
    end
  endgenerate

endmodule

// File: tb/tb_actuador_valvulas.sv
module tb_actuador_valvulas;

  localparam int MIN_ON  = 4;
  localparam int MIN_OFF = 4;
  localparam int MAX_ON  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] C = 2'b00;
  logic [1:0] Pout = 2'b00;
  logic       ack = 1'b0;
  logic [1:0] V, Alarm, Tout;

  int n_checks = 0;
  int n_fail   = 0;

  actuador_valvulas #(
    .MIN_ON(MIN_ON),
    .MIN_OFF(MIN_OFF),
    .MAX_ON(MAX_ON),
    .CW(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .C(C),
    .Pout(Pout),
    .ack(ack),
    .V(V),
    .Alarm(Alarm),
    .Tout(Tout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. It tracks how long the valve has been on or cooling,
  // in plain cycle counts, and derives the outputs from the mode.
  localparam int M_IDLE = 0, M_ON = 1, M_REST = 2, M_ALARM = 3;
  int  m_mode [2];
  int  m_on   [2];   // cycles the valve has been on so far
  int  m_rest [2];   // cycles spent cooling so far
  bit  m_tout [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = M_IDLE; m_on[k] = 0; m_rest[k] = 0; m_tout[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        case (m_mode[k])
          M_IDLE:
            if (Pout[k]) begin m_mode[k] = M_ALARM; m_tout[k] = 0; end
            else if (C[k]) begin m_mode[k] = M_ON; m_on[k] = 1; end
          M_ON:
            if (Pout[k]) begin m_mode[k] = M_ALARM; m_tout[k] = 0; end
            else if (!C[k] && m_on[k] >= MIN_ON) begin m_mode[k] = M_REST; m_rest[k] = 1; end
            else if (m_on[k] == MAX_ON) begin m_mode[k] = M_ALARM; m_tout[k] = 1; end
            else m_on[k]++;
          M_REST:
            if (Pout[k]) begin m_mode[k] = M_ALARM; m_tout[k] = 0; end
            else if (m_rest[k] == MIN_OFF) m_mode[k] = M_IDLE;
            else m_rest[k]++;
          default:
            if (ack && !Pout[k]) begin m_mode[k] = M_IDLE; m_tout[k] = 0; end
        endcase
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    logic [1:0] ev, ea, et;
    for (int k = 0; k < 2; k++) begin
      ev[k] = (m_mode[k] == M_ON);
      ea[k] = (m_mode[k] == M_ALARM);
      et[k] = (m_mode[k] == M_ALARM) && m_tout[k];
    end
    check("model_V", {6'd0, V}, {6'd0, ev});
    check("model_Alarm", {6'd0, Alarm}, {6'd0, ea});
    check("model_Tout", {6'd0, Tout}, {6'd0, et});
  end

  // Advance n rising edges; inputs are changed 2 time units after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int first_hi, last_hi;
    bit v1_seen;

    reset = 1'b1;
    step(2);
    check("reset_V", {6'd0, V}, 8'h00);
    check("reset_Alarm", {6'd0, Alarm}, 8'h00);
    check("reset_Tout", {6'd0, Tout}, 8'h00);
    reset = 1'b0;
    step(1);
    check("post_reset_V", {6'd0, V}, 8'h00);

    // Test 1: C=01 held for 20 cycles runs into the timeout.
    C = 2'b01;
    cnt = 0; v1_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (i == 0) check("t1_first_cycle_V0", {7'd0, V[0]}, 8'h01);
      if (V[0]) cnt++;
      if (V[1]) v1_seen = 1;
    end
    check("t1_high_cycles", cnt[7:0], 8'd16);
    check("t1_Alarm", {6'd0, Alarm}, 8'h01);
    check("t1_Tout", {6'd0, Tout}, 8'h01);
    check("t1_V1_quiet", {7'd0, v1_seen}, 8'h00);
    C = 2'b00; ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("t1_ack_clears", {6'd0, Alarm}, 8'h00);

    // Test 2: one-cycle request on channel 1, plus a request pulse during cool-down.
    C = 2'b10;
    step(1);
    C = 2'b00;
    cnt = V[1] ? 1 : 0; first_hi = V[1] ? 1 : 0; last_hi = first_hi;
    for (int i = 2; i <= 10; i++) begin
      C = (i == 7) ? 2'b10 : 2'b00;
      step(1);
      if (V[1]) begin
        cnt++;
        if (first_hi == 0) first_hi = i;
        last_hi = i;
      end
    end
    C = 2'b00;
    check("t2_high_cycles", cnt[7:0], 8'd4);
    check("t2_first_high", first_hi[7:0], 8'd1);
    check("t2_last_high", last_hi[7:0], 8'd4);
    step(2);

    // Test 3: a fault mid-run locks the channel.
    C = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      Pout = (i >= 6) ? 2'b01 : 2'b00;
      step(1);
      if (i == 5) check("t3_running", {7'd0, V[0]}, 8'h01);
      if (i == 6) begin
        check("t3_V_drop", {6'd0, V}, 8'h00);
        check("t3_Alarm", {6'd0, Alarm}, 8'h01);
        check("t3_Tout", {6'd0, Tout}, 8'h00);
      end
    end
    C = 2'b00; ack = 1'b1;
    step(1);
    check("t3_ack_blocked", {6'd0, Alarm}, 8'h01);
    Pout = 2'b00;
    step(1);
    ack = 1'b0;
    check("t3_ack_clears", {6'd0, Alarm}, 8'h00);
    step(1);

    // Test 4: C=11 with Pout=10.
    C = 2'b11; Pout = 2'b10;
    step(1);
    check("t4_V", {6'd0, V}, 8'h01);
    check("t4_Alarm", {6'd0, Alarm}, 8'h02);
    check("t4_Tout", {6'd0, Tout}, 8'h00);
    C = 2'b01; Pout = 2'b00; ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("t4_ack_ch1_only", {6'd0, Alarm}, 8'h00);
    check("t4_ch0_still_runs", {6'd0, V}, 8'h01);
    C = 2'b00;
    step(10);

    // Test 5: release on the same edge as the timeout.
    C = 2'b01;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (V[0]) cnt++;
    end
    check("t5_high_cycles", cnt[7:0], 8'd16);
    C = 2'b00;
    step(1);
    check("t5_V_released", {6'd0, V}, 8'h00);
    check("t5_no_alarm", {6'd0, Alarm}, 8'h00);
    step(6);

    // Test 6: asynchronous reset mid-run.
    C = 2'b01;
    step(2);
    check("t6_running", {6'd0, V}, 8'h01);
    #1 reset = 1'b1;
    #1;
    check("t6_async_V", {6'd0, V}, 8'h00);
    C = 2'b00;
    step(1);
    reset = 1'b0;
    step(1);
    check("t6_after_V", {6'd0, V}, 8'h00);
    check("t6_after_Alarm", {6'd0, Alarm}, 8'h00);
    check("t6_after_Tout", {6'd0, Tout}, 8'h00);
    C = 2'b01;
    step(1);
    C = 2'b00;
    cnt = V[0] ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (V[0]) cnt++;
    end
    check("t6_min_run", cnt[7:0], 8'd4);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
